// File: rtl/frame_fifo_pkg.sv
// Shared types and helpers for the frame-aware store-and-forward FIFO.
package frame_fifo_pkg;

  typedef enum logic {PASS, DROP} frame_fifo_state_t;

  localparam int STAT_WIDTH = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, 1-cycle registered read, no reset.
module fifo_ram
  import frame_fifo_pkg::*;
#(
  parameter int WIDTH      = 9,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; non-blocking
  // assignments keep read-before-write ordering identical in sim and silicon.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_fifo.sv
// Frame-aware store-and-forward FIFO with FWFT valid/ready read side.
// Optional statistics counters are enabled with FRAME_FIFO_STATS_EN.
module frame_fifo
  import frame_fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH              = 2048,
  parameter int ADDR_WIDTH         = $clog2(DEPTH),
  parameter int ALMOST_FULL_THRESH = DEPTH - 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  s_err,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  drop
`ifdef FRAME_FIFO_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_frames,
  output logic [STAT_WIDTH-1:0] stat_drops
`endif
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = PW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL   = PW'(ALMOST_FULL_THRESH);

  frame_fifo_state_t state;
  logic [ADDR_WIDTH:0] wr_ptr, wr_cmt, rd_ptr, rf_ptr;
  logic running, ram_vld;
  logic full, accept, wr_en, commit, rd_en, mid_move, pop;
  logic [DATA_WIDTH:0] ram_q;

  assign level       = wr_ptr - rd_ptr;
  assign almost_full = level >= AF_LEVEL;
  assign full        = level == FULL_LEVEL;
  assign s_ready     = running && ((state == DROP) || !full);
  assign accept      = s_valid && s_ready;
  assign wr_en       = accept && (state == PASS);
  assign commit      = wr_en && s_last && !s_err;

  // rd_ptr frees space only on consumption; rf_ptr runs ahead to prefetch
  // the RAM stage and the output register.
  assign pop      = m_valid && m_ready;
  assign mid_move = ram_vld && (!m_valid || m_ready);
  assign rd_en    = (wr_cmt != rf_ptr) && (!ram_vld || mid_move);

  fifo_ram #(
    .WIDTH      (DATA_WIDTH + 1),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data ({s_last, s_data}),
    .rd_en   (rd_en),
    .rd_addr (rf_ptr[ADDR_WIDTH-1:0]),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= PASS;
      wr_ptr  <= '0;
      wr_cmt  <= '0;
      rd_ptr  <= '0;
      rf_ptr  <= '0;
      running <= 1'b0;
      ram_vld <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      drop    <= 1'b0;
    end else begin
      running <= 1'b1;
      drop    <= 1'b0;
      case (state)
        PASS: begin
          if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (s_last && s_err) begin
              wr_ptr <= wr_cmt;
              drop   <= 1'b1;
            end else if (s_last) begin
              wr_cmt <= wr_ptr + 1'b1;
            end
          end else if (s_valid && full && (wr_cmt == rd_ptr)) begin
            // Frame occupies the whole FIFO with nothing to drain: it can never commit.
            state  <= DROP;
            wr_ptr <= wr_cmt;
          end
        end
        DROP: begin
          if (accept && s_last) begin
            drop  <= 1'b1;
            state <= PASS;
          end
        end
        default: state <= PASS;
      endcase

      if (rd_en) rf_ptr <= rf_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;

      if (rd_en)         ram_vld <= 1'b1;
      else if (mid_move) ram_vld <= 1'b0;

      if (mid_move) begin
        {m_last, m_data} <= ram_q;
        m_valid          <= 1'b1;
      end else if (pop) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef FRAME_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_frames <= '0;
      stat_drops  <= '0;
    end else begin
      if (commit) stat_frames <= sat_inc(stat_frames);
      if (drop)   stat_drops  <= sat_inc(stat_drops);
    end
  end
`else
  // Statistics counters are absent in this build; commit is only used internally.
  logic unused_commit;
  assign unused_commit = commit;
`endif

endmodule
